// File: rtl/serializer_pkg.sv
// Shared types and width helpers for the bit serializer and its FIFO.
package serializer_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } shift_state_t;

  // Number of bits needed to hold any value in 0..n.
  function automatic int unsigned bits_for(input int unsigned n);
    int unsigned b;
    b = 1;
    while ((n >> b) != 0) b++;
    return b;
  endfunction

endpackage

// File: rtl/serializer_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with flush clear; storage is not reset, only pointers and count.
module serializer_fifo
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            flush,
  input  logic                            push,
  input  logic [WIDTH-1:0]                wr_data,
  input  logic                            pop,
  output logic [WIDTH-1:0]                rd_data,
  output logic                            full,
  output logic                            empty,
  output logic [bits_for(DEPTH)-1:0]      count
);

  localparam int unsigned CW = bits_for(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: buffers WIDTH-bit words and shifts them out one bit per clock on x.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CW = bits_for(DEPTH);
  localparam int unsigned BW = bits_for(WIDTH - 1);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  shift_state_t     state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = !flush && !empty && ((state == IDLE) || (bitcnt == LAST));
  assign busy     = (state == SHIFT) || (count != '0);

  serializer_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // A pop covers both the IDLE load and the gapless reload on the last bit of SHIFT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      x           <= IDLE_BIT;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      bitcnt      <= '0;
      x           <= IDLE_BIT;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
    end else if (pop) begin
      state       <= SHIFT;
      shreg       <= advance(head);
      bitcnt      <= '0;
      x           <= first_bit(head);
      x_valid     <= 1'b1;
      frame_start <= 1'b1;
    end else if ((state == SHIFT) && (bitcnt != LAST)) begin
      shreg       <= advance(shreg);
      bitcnt      <= bitcnt + BW'(1);
      x           <= first_bit(shreg);
      frame_start <= 1'b0;
    end else begin
      state       <= IDLE;
      bitcnt      <= '0;
      x           <= IDLE_BIT;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench: two serializers (MSB-first and LSB-first) share one stimulus stream.
module tb_bit_serializer;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;

  logic in_ready_m, x_m, x_valid_m, frame_start_m, busy_m;
  logic in_ready_l, x_l, x_valid_l, frame_start_l, busy_l;

  int unsigned n_tests;
  int unsigned n_fail;

  bit_serializer #(
    .WIDTH     (8),
    .DEPTH     (4),
    .MSB_FIRST (1'b1),
    .IDLE_BIT  (1'b0)
  ) dut_m (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready_m),
    .x           (x_m),
    .x_valid     (x_valid_m),
    .frame_start (frame_start_m),
    .busy        (busy_m)
  );

  bit_serializer #(
    .WIDTH     (8),
    .DEPTH     (4),
    .MSB_FIRST (1'b0),
    .IDLE_BIT  (1'b0)
  ) dut_l (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready_l),
    .x           (x_l),
    .x_valid     (x_valid_l),
    .frame_start (frame_start_l),
    .busy        (busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_xv_m"}, 64'(x_valid_m), 64'd0);
    check({tag, "_x_m"},  64'(x_m),       64'd0);
    check({tag, "_bsy_m"}, 64'(busy_m),   64'd0);
    check({tag, "_xv_l"}, 64'(x_valid_l), 64'd0);
    check({tag, "_x_l"},  64'(x_l),       64'd0);
    check({tag, "_bsy_l"}, 64'(busy_l),   64'd0);
  endtask

  // em/el: expected bits for each DUT, bit n-1 emitted first.
  task automatic expect_stream(input string tag, input int unsigned n,
                               input logic [63:0] em, input logic [63:0] el);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      in_valid = 1'b0;
      check($sformatf("%s_x_m[%0d]", tag, i),  64'(x_m),           64'(em[n-1-i]));
      check($sformatf("%s_x_l[%0d]", tag, i),  64'(x_l),           64'(el[n-1-i]));
      check($sformatf("%s_xv_m[%0d]", tag, i), 64'(x_valid_m),     64'd1);
      check($sformatf("%s_xv_l[%0d]", tag, i), 64'(x_valid_l),     64'd1);
      check($sformatf("%s_fs_m[%0d]", tag, i), 64'(frame_start_m), 64'(i % 8 == 0));
      check($sformatf("%s_fs_l[%0d]", tag, i), 64'(frame_start_l), 64'(i % 8 == 0));
    end
    tick();
    check_idle({tag, "_end"});
    check({tag, "_end_fs_m"}, 64'(frame_start_m), 64'd0);
  endtask

  initial begin
    logic [7:0]  words [5];
    int unsigned acc, nbits, first_e, last_e;
    logic [39:0] sm, sl;

    n_tests  = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    flush    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;

    // 1. reset
    repeat (3) tick();
    check_idle("rst_hold");
    reset_n = 1'b1;
    #1;
    check_idle("rst");
    check("rst_fs_m", 64'(frame_start_m), 64'd0);
    check("rst_rdy_m", 64'(in_ready_m), 64'd1);
    check("rst_rdy_l", 64'(in_ready_l), 64'd1);
    tick();

    // 2. single word 8'hD0
    in_data  = 8'hD0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_lat_xv", 64'(x_valid_m), 64'd0);
    check("single_busy",   64'(busy_m),    64'd1);
    expect_stream("single", 8, 64'h00D0, 64'h000B);
    tick();

    // 3. back-to-back 8'hA5, 8'h3C
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_data  = 8'h3C;
    expect_stream("b2b", 16, 64'hA53C, 64'hA53C);
    tick();

    // 4. fill with in_valid held high
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    acc = 0; nbits = 0; first_e = 999; last_e = 0; sm = '0; sl = '0;
    for (int unsigned e = 0; e < 45; e++) begin
      in_valid = (e <= 9);
      in_data  = (acc < 5) ? words[acc] : 8'h00;
      if (in_valid && in_ready_m) acc++;
      tick();
      if (e <= 9) begin
        check($sformatf("fill_rdy_m[%0d]", e), 64'(in_ready_m), 64'((e < 4) || (e == 9)));
        check($sformatf("fill_rdy_l[%0d]", e), 64'(in_ready_l), 64'((e < 4) || (e == 9)));
      end
      if (x_valid_m) begin
        sm = {sm[38:0], x_m};
        sl = {sl[38:0], x_l};
        nbits++;
        if (first_e == 999) first_e = e;
        last_e = e;
      end
    end
    in_valid = 1'b0;
    check("fill_acc",    64'(acc),     64'd5);
    check("fill_nbits",  64'(nbits),   64'd40);
    check("fill_first",  64'(first_e), 64'd1);
    check("fill_last",   64'(last_e),  64'd40);
    check("fill_str_m",  64'(sm),      64'h11_2233_4455);
    check("fill_str_l",  64'(sl),      64'h88_44CC_22AA);
    check_idle("fill_end");

    // 5. flush during bit 3 with two words buffered
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    in_data  = 8'h81;
    tick();
    in_data  = 8'h7E;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("fl_pre_xv", 64'(x_valid_m), 64'd1);
    check("fl_pre_x",  64'(x_m),       64'd0);
    flush = 1'b1;
    #1;
    check("fl_rdy_m", 64'(in_ready_m), 64'd0);
    tick();
    flush = 1'b0;
    check_idle("fl_post");
    tick();
    tick();
    check_idle("fl_hold");
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("fl_ff_lat", 64'(x_valid_m), 64'd0);
    expect_stream("fl_ff", 8, 64'hFF, 64'hFF);
    tick();

    // 6. asynchronous reset during bit 5
    in_valid = 1'b1;
    in_data  = 8'h96;
    tick();
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("ar_pre_x",  64'(x_m),       64'd1);
    check("ar_pre_xv", 64'(x_valid_m), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("ar_mid");
    check("ar_mid_fs", 64'(frame_start_m), 64'd0);
    #2;
    reset_n = 1'b1;
    #1;
    check("ar_rdy", 64'(in_ready_m), 64'd1);
    tick();
    check_idle("ar_post");
    tick();
    tick();
    check_idle("ar_empty");
    check("ar_rdy2", 64'(in_ready_m), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
